// File: rtl/aes_key_schedule.sv
// Iterative AES-128/192/256 key schedule: one 32-bit word per cycle, 128-bit round keys on valid/ready.
// Define AES_KEY_STORE_EN to add a random-access round-key store behind rd_addr/rd_data.
module aes_key_schedule #(
  parameter int KEY_BITS = 128
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [255:0] key_in,
  output logic         busy,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [3:0]   rk_index,
  output logic [127:0] round_key,
  output logic         done,
  input  logic [3:0]   rd_addr,
  output logic [127:0] rd_data
);

  localparam int NK = KEY_BITS / 32;
  localparam int NR = NK + 6;
  localparam logic [5:0] J_NK   = 6'(NK);
  localparam logic [5:0] J_LAST = 6'(4 * NR + 3);
  localparam logic [2:0] POS_LAST = 3'(NK - 1);

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t       state, state_next;
  logic [31:0]  win [0:NK-1];
  logic [31:0]  obuf [0:2];
  logic [5:0]   j;
  logic [2:0]   pos;
  logic [7:0]   rcon;
  logic         gen, hs;
  logic [31:0]  sub_in, sub_out, t, new_word;
  logic         unused_inputs;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // The window always holds the last NK words with the oldest (w[j-NK]) in slot 0;
  // during the first NK words it simply rotates the key words through.
  always_comb begin
    gen      = (state == RUN) && !(rk_valid && !rk_ready);
    hs       = rk_valid && rk_ready;
    sub_in   = (pos == 3'd0) ? {win[NK-1][23:0], win[NK-1][31:24]} : win[NK-1];
    sub_out  = {SBOX[sub_in[31:24]], SBOX[sub_in[23:16]], SBOX[sub_in[15:8]], SBOX[sub_in[7:0]]};
    t        = win[NK-1];
    new_word = win[0];
    if (j >= J_NK) begin
      if (pos == 3'd0)
        t = sub_out ^ {rcon, 24'h0};
      else if (NK == 8 && pos == 3'd4)
        t = sub_out;
      new_word = win[0] ^ t;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (gen && j == J_LAST) state_next = DRAIN;
      DRAIN:   if (hs) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      j         <= '0;
      pos       <= '0;
      rcon      <= 8'h01;
      rk_valid  <= 1'b0;
      rk_index  <= '0;
      round_key <= '0;
      done      <= 1'b0;
    end else begin
      state <= state_next;
      done  <= (state == DRAIN) && hs;
      if (state == IDLE && start) begin
        j    <= '0;
        pos  <= '0;
        rcon <= 8'h01;
      end
      if (hs)
        rk_valid <= 1'b0;
      if (gen) begin
        j   <= j + 6'd1;
        pos <= (pos == POS_LAST) ? 3'd0 : pos + 3'd1;
        if (j >= J_NK && pos == 3'd0)
          rcon <= xtime(rcon);
        if (j[1:0] == 2'd3) begin
          round_key <= {obuf[0], obuf[1], obuf[2], new_word};
          rk_index  <= j[5:2];
          rk_valid  <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      for (int i = 0; i < NK; i++)
        win[i] <= key_in[255 - 32*i -: 32];
    end else if (gen) begin
      for (int i = 0; i < NK - 1; i++)
        win[i] <= win[i+1];
      win[NK-1] <= new_word;
      obuf[0]   <= obuf[1];
      obuf[1]   <= obuf[2];
      obuf[2]   <= new_word;
    end
  end

  assign busy = (state != IDLE);

`ifdef AES_KEY_STORE_EN
  logic [127:0] store [0:NR];

  always_ff @(posedge clk) begin
    if (hs)
      store[rk_index] <= round_key;
  end

  always_ff @(posedge clk) begin
    if (rst)
      rd_data <= '0;
    else
      rd_data <= (rd_addr <= 4'(NR)) ? store[rd_addr] : '0;
  end

  assign unused_inputs = ^key_in;
`else
  assign rd_data       = '0;
  assign unused_inputs = ^{key_in, rd_addr};
`endif

endmodule

// File: tb/tb_aes_key_schedule.sv
// Scoreboard bench for aes_key_schedule: one instance per key size, checked against a
// GF(2^8)-arithmetic reference model of the AES key expansion.
module tb_aes_key_schedule;

  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   start, rk_ready, busy, rk_valid, done;
  logic [255:0] key_in;
  logic [3:0]   rd_addr;
  logic [3:0]   rk_index [3];
  logic [127:0] round_key [3];
  logic [127:0] rd_data [3];

  int vectors = 0;
  int miscompares = 0;

  typedef struct { int k; int idx; logic [127:0] key; } exp_t;
  exp_t         exp_q [$];
  logic [7:0]   sbox_m [256];
  logic [127:0] exp_rk [15];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    aes_key_schedule #(.KEY_BITS(128 + 64*g)) dut (
      .clk(clk), .rst(rst), .start(start[g]), .key_in(key_in), .busy(busy[g]),
      .rk_valid(rk_valid[g]), .rk_ready(rk_ready[g]), .rk_index(rk_index[g]),
      .round_key(round_key[g]), .done(done[g]), .rd_addr(rd_addr), .rd_data(rd_data[g])
    );
  end

  task automatic checkOutput(input string name, input logic [255:0] actual, input logic [255:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box from its definition: multiplicative inverse (x^254) followed by the affine map.
  task automatic buildSbox();
    logic [7:0] b, inv;
    for (int x = 0; x < 256; x++) begin
      b = 8'(x);
      inv = 8'h01;
      for (int i = 0; i < 254; i++) inv = gmul(inv, b);
      sbox_m[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                  ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subWord(input logic [31:0] x);
    return {sbox_m[x[31:24]], sbox_m[x[23:16]], sbox_m[x[15:8]], sbox_m[x[7:0]]};
  endfunction

  task automatic modelKeys(input int k, input logic [255:0] key);
    int nk, nr;
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0] rc;
    nk = 4 + 2*k;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
    for (int j = nk; j < 4*nr + 4; j++) begin
      t = w[j-1];
      if (j % nk == 0) begin
        t = subWord({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk == 8 && j % nk == 4) begin
        t = subWord(t);
      end
      w[j] = w[j-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic pushExpected(input int k, input int upto);
    for (int r = 0; r <= upto; r++) exp_q.push_back('{k, r, exp_rk[r]});
  endtask

  function automatic logic [255:0] randKey();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  // Runs one schedule on instance k; done_cyc counts edges from raising start to seeing done.
  task automatic applyStimulus(input int k, input int stall_len, input bit rand_ready,
                               input bit abort, output int done_cyc);
    int stall_left, nd;
    bit pulsed;
    stall_left = stall_len;
    pulsed = 1'b0;
    done_cyc = -1;
    start[k] = 1'b1;
    for (int c = 1; c <= 400 && done_cyc < 0; c++) begin
      @(posedge clk); #1;
      start[k] = 1'b0;
      if (c == 1) checkOutput("busy_after_start", busy[k], 1);
      if (done[k]) begin
        done_cyc = c;
        checkOutput("busy_at_done", busy[k], 0);
      end else if (abort && rk_valid[k] && rk_index[k] == 4'd6 && !pulsed) begin
        start[k] = 1'b1;
        key_in = randKey();
        pulsed = 1'b1;
      end else if (abort && rk_valid[k] && rk_index[k] == 4'd8) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("abort_busy", busy[k], 0);
        checkOutput("abort_rk_valid", rk_valid[k], 0);
        nd = 0;
        for (int i = 0; i < 60; i++) begin
          @(posedge clk); #1;
          if (done[k]) nd++;
        end
        checkOutput("abort_no_done", nd, 0);
        done_cyc = 0;
      end
      if (stall_left > 0 && rk_valid[k] && rk_index[k] == 4'd3) begin
        rk_ready[k] = 1'b0;
        stall_left--;
      end else begin
        rk_ready[k] = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
    rk_ready[k] = 1'b1;
    if (done_cyc < 0) checkOutput("done_timeout", 0, 1);
    if (done_cyc > 0) begin
      @(posedge clk); #1;
      checkOutput("done_pulse_width", done[k], 0);
    end
  endtask

  // Monitor: pops the scoreboard on every handshake and checks stalled outputs hold still.
  initial begin
    bit [2:0]     hold;
    logic [131:0] held [3];
    exp_t         e;
    hold = '0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (rst) begin
          hold[k] = 1'b0;
        end else begin
          if (hold[k])
            checkOutput($sformatf("stall_hold_k%0d", k), {rk_valid[k], rk_index[k], round_key[k]}, {1'b1, held[k]});
          if (rk_valid[k] && rk_ready[k]) begin
            if (exp_q.size() == 0) begin
              checkOutput($sformatf("unexpected_rk_k%0d", k), 1, 0);
            end else begin
              e = exp_q.pop_front();
              checkOutput($sformatf("rk_k%0d_r%0d", e.k, e.idx),
                          {4'(k), rk_index[k], round_key[k]}, {4'(e.k), 4'(e.idx), e.key});
            end
          end
          hold[k] = rk_valid[k] && !rk_ready[k];
          held[k] = {rk_index[k], round_key[k]};
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int dc;
    buildSbox();
    rst = 1'b1;
    start = '0;
    rk_ready = 3'b111;
    key_in = '0;
    rd_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("reset_k%0d", k),
                  {busy[k], rk_valid[k], done[k], rk_index[k]}, 0);
      checkOutput($sformatf("reset_round_key_k%0d", k), round_key[k], 0);
      checkOutput($sformatf("reset_rd_data_k%0d", k), rd_data[k], 0);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    key_in = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    modelKeys(0, key_in);
    exp_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    exp_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    pushExpected(0, 10);
    applyStimulus(0, 0, 1'b0, 1'b0, dc);
    checkOutput("done_cycle_aes128", dc, 46);

    key_in = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    modelKeys(1, key_in);
    exp_rk[12] = 128'he98ba06f448c773c8ecc720401002202;
    pushExpected(1, 12);
    applyStimulus(1, 0, 1'b0, 1'b0, dc);
    checkOutput("done_cycle_aes192", dc, 54);

    key_in = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    modelKeys(2, key_in);
    exp_rk[14] = 128'hfe4890d1e6188d0b046df344706c631e;
    pushExpected(2, 14);
    applyStimulus(2, 0, 1'b0, 1'b0, dc);
    checkOutput("done_cycle_aes256", dc, 62);

    for (int k = 0; k < 3; k++) begin
      key_in = randKey();
      modelKeys(k, key_in);
      pushExpected(k, 10 + 2*k);
      applyStimulus(k, 5, 1'b0, 1'b0, dc);
      checkOutput($sformatf("done_cycle_stall_k%0d", k), dc, 4*(10 + 2*k) + 11);
    end

    for (int k = 0; k < 3; k++) begin
      key_in = randKey();
      modelKeys(k, key_in);
      pushExpected(k, 10 + 2*k);
      applyStimulus(k, 0, 1'b1, 1'b0, dc);
    end

    key_in = randKey();
    modelKeys(0, key_in);
    pushExpected(0, 7);
    applyStimulus(0, 0, 1'b0, 1'b1, dc);

    key_in = randKey();
    modelKeys(0, key_in);
    pushExpected(0, 10);
    applyStimulus(0, 0, 1'b0, 1'b0, dc);
    checkOutput("done_cycle_after_abort", dc, 46);

`ifdef AES_KEY_STORE_EN
    for (int a = 10; a >= 0; a--) begin
      rd_addr = 4'(a);
      @(posedge clk); #1;
      checkOutput($sformatf("store_rd%0d", a), rd_data[0], exp_rk[a]);
    end
    rd_addr = 4'd12;
    @(posedge clk); #1;
    checkOutput("store_rd12", rd_data[0], 0);
`else
    for (int i = 0; i < 4; i++) begin
      rd_addr = 4'($urandom_range(0, 15));
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) checkOutput($sformatf("rd_data_off_k%0d", k), rd_data[k], 0);
    end
`endif

    repeat (2) @(negedge clk);
    checkOutput("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/aes_key_schedule.md
# aes_key_schedule

Iterative, parametrised AES key-schedule engine for AES-128/192/256, producing one 32-bit schedule word per cycle and presenting each 128-bit round key on a valid/ready output. It is the sequential successor to the single-round combinational expansion stage. It feeds the encryptor and decryptor round pipelines, which consume round keys 0..Nr in order. An optional on-chip key store allows random-access and reverse-order fetch for decryption.

## Interface

Parameters:
- KEY_BITS, 128: key length; legal values are 128, 192 and 256. Derived values: NK = KEY_BITS/32 and NR = NK+6.

Ports:
- clk, input, 1: single clock.
- rst, input, 1: synchronous, active-high reset.
- start, input, 1: begin expansion; sampled only in IDLE.
- key_in, input, 256: cipher key, MSB-aligned; w0 = key_in[255:224]; bits below 256-KEY_BITS are ignored.
- busy, output, 1: expansion in progress.
- rk_valid, output, 1: round_key holds a complete round key.
- rk_ready, input, 1: consumer accepts round_key.
- rk_index, output, 4: round number of round_key (0..NR).
- round_key, output, 128: {w[4r], w[4r+1], w[4r+2], w[4r+3]}, with the first word in [127:96].
- done, output, 1: one-cycle pulse when the final round key is accepted.
- rd_addr, input, 4: key-store read address (see Configuration).
- rd_data, output, 128: key-store read data.

## Operation

- States: IDLE, RUN, DRAIN.
- IDLE → RUN when start=1. On that edge the block latches key_in into an NK-word window register, sets word counter j=0 and Rcon=8'h01, and sets busy=1.
- RUN generates one word per non-stalled cycle:
  - For j<NK, the word is taken directly from the key window.
  - For j≥NK, t = w[j-1]:
    - if j%NK==0: t = SubWord(RotWord(t)) ^ {Rcon,24'h0}, then Rcon = xtime(Rcon);
    - else if NK==8 and j%NK==4: t = SubWord(t);
    - w[j] = w[j-NK] ^ t.
  - The window shifts left by one word; w[j] enters as the newest word.
- Generated words accumulate into a 4-word output buffer. When j%4==3, the buffer is copied to round_key, rk_index=j/4, and rk_valid=1.
- Stall: no word is generated while rk_valid=1 and rk_ready=0. round_key and rk_index hold stable. rk_valid drops only on handshake (rk_valid and rk_ready both high).
- After word 4·NR+3 (index 43, 51 or 59), RUN → DRAIN. DRAIN → IDLE on acceptance of the round-NR key. done pulses in the cycle after that handshake; busy falls on the same edge.
- start asserted while busy is ignored; the running schedule is unaffected.
- xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1B : 8'h00), 8-bit wide.
- SubWord applies the standard AES S-box bytewise; it is implemented as four parallel combinational S-box lookups.

## Timing

- Reset: busy=0, rk_valid=0, done=0, rk_index=0, round_key=0, rd_data=0. State is IDLE, j=0, Rcon=8'h01.
- Reset mid-expansion aborts immediately to IDLE. No done pulse is produced, and the key-store contents are undefined.
- With rk_ready tied high and start accepted at edge E0:
  - word j is registered at edge E(j+1);
  - rk_valid for round r rises after edge E(4r+4) and lasts one cycle;
  - done rises after edge E(4·NR+5).
- Throughput is one word per cycle. The total of 4·(NR+1) words takes 44, 52 or 60 cycles.
- Each stall cycle delays every later event by exactly one cycle.

## Configuration

- AES_KEY_STORE_EN:
  - When defined, a 15×128 register file captures each round key at the rk_valid handshake, written at address rk_index. rd_data = store[rd_addr] with 1-cycle read latency. Reads of addresses > NR return 0. Entries stay valid until the next start.
  - When undefined, there is no storage; rd_addr is ignored and rd_data is held at 0.

## Test plan

- AES-128, key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1:
  - round 1 = a0fafe1788542cb123a339392a6c7605;
  - round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6;
  - done 46 cycles after start.
- AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b: round 12 = e98ba06f448c773c8ecc720401002202, and 13 rk_valid pulses.
- AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4: round 14 = fe4890d1e6188d0b046df344706c631e, which exercises the j%8==4 SubWord path.
- Backpressure: hold rk_ready=0 for 5 cycles at round 3. round_key and rk_index must stay stable, no words may be skipped, final keys are unchanged, and done is delayed by exactly 5 cycles.
- Pulse start again at round 6 (ignored), then assert rst at round 8. busy must go to 0 the next cycle, no done pulse may occur, and a new start then yields a correct round 0.
- With AES_KEY_STORE_EN, after AES-128 completion read rd_addr=10 down to 0. rd_data must match each round key one cycle later, and rd_addr=12 must read 0.
